// File: rtl/biss_pkg.sv
// Shared types and constants for the BiSS-C slave and sniffer.
package biss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_START,
        ST_CDS,
        ST_POSN,
        ST_STAT,
        ST_CRC,
        ST_TIMEOUT
    } biss_state_e;

    localparam logic [5:0] CRC6_POLY       = 6'h03;
    localparam int         CRC6_WIDTH      = 6;
    localparam int         MAX_POSN_BITS   = 32;
    localparam int         MAX_STATUS_BITS = 8;

    // Field lengths arrive as 8-bit config; anything over the maximum saturates.
    function automatic logic [5:0] clamp_len(input logic [7:0] len, input int max_len);
        return (int'(len) > max_len) ? 6'(max_len) : len[5:0];
    endfunction

endpackage

// File: rtl/biss_crc6.sv
// Serial CRC6 (x^6+x+1), MSB-first, one message bit per enable; shared with the sniffer.
module biss_crc6
    import biss_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  din,
    output logic [CRC6_WIDTH-1:0] crc
);

    logic fb;

    assign fb = din ^ crc[CRC6_WIDTH-1];

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            crc <= '0;
        else if (clr)
            crc <= '0;
        else if (en)
            crc <= {crc[CRC6_WIDTH-2:0], 1'b0} ^ (fb ? CRC6_POLY : '0);
    end

endmodule

// File: rtl/biss_slave.sv
// BiSS-C slave / encoder emulator: answers MA with ack, start, CDS, position, status, CRC6.
// Optional BISS_SLAVE_CRC_ERR_EN adds crc_err_i to corrupt the transmitted CRC LSB.
module biss_slave
    import biss_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2500,
    parameter int ACK_CYCLES     = 1
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [7:0]  BITS,
    input  logic [7:0]  STATUS_BITS,
    input  logic [7:0]  CRC_BITS,
    input  logic [31:0] posn_i,
    input  logic [7:0]  status_i,
`ifdef BISS_SLAVE_CRC_ERR_EN
    input  logic        crc_err_i,
`endif
    input  logic        biss_sck_i,
    output logic        biss_dat_o,
    output logic        busy_o,
    output logic        frame_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sck_sync;
    logic                   sck_prev, sck_s, sck_rise, sck_fall;

    biss_state_e state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        dat_q, dat_d, busy_q, busy_d, frame_q, frame_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [31:0] posn_q;
    logic [7:0]  status_q;
    logic [5:0]  bits_q, sbits_q, crc_len;
    logic        err_in, err_q;
    logic        latch, crc_clr, crc_en, crc_din, tmr_hit;
    logic [CRC6_WIDTH-1:0] crc;

`ifdef BISS_SLAVE_CRC_ERR_EN
    assign err_in = crc_err_i;
`else
    assign err_in = 1'b0;
`endif

    // Only CRC6 is implemented; other requested widths still send six bits.
    assign crc_len = (CRC_BITS == 8'd6) ? 6'(CRC6_WIDTH) : 6'(CRC6_WIDTH);

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev;
    assign sck_fall = ~sck_s & sck_prev;
    assign tmr_hit  = (tmr_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sck_sync <= '1;
            sck_prev <= 1'b1;
        end else begin
            sck_sync <= SYNC_STAGES'({sck_sync, biss_sck_i});
            sck_prev <= sck_s;
        end
    end

    biss_crc6 u_crc (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .clr       (crc_clr),
        .en        (crc_en),
        .din       (crc_din),
        .crc       (crc)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dat_q    <= 1'b1;
            busy_q   <= 1'b0;
            frame_q  <= 1'b0;
            tmr_q    <= '0;
            posn_q   <= '0;
            status_q <= '0;
            bits_q   <= '0;
            sbits_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_q   <= dat_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            tmr_q   <= tmr_d;
            if (latch) begin
                posn_q   <= posn_i;
                status_q <= status_i;
                bits_q   <= clamp_len(BITS, MAX_POSN_BITS);
                sbits_q  <= clamp_len(STATUS_BITS, MAX_STATUS_BITS);
                err_q    <= err_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dat_d   = dat_q;
        busy_d  = busy_q;
        frame_d = 1'b0;
        tmr_d   = (sck_rise || sck_fall) ? '0 : tmr_q + TW'(1);
        latch   = 1'b0;
        crc_clr = 1'b0;
        crc_en  = 1'b0;
        crc_din = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_d = '0;
                if (sck_fall) begin
                    latch   = 1'b1;
                    crc_clr = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 6'(ACK_CYCLES);
                    state_d = ST_ACK;
                end
            end
            ST_ACK: if (sck_rise) begin
                dat_d = 1'b0;
                if (cnt_q <= 6'd1) state_d = ST_START;
                else               cnt_d   = cnt_q - 6'd1;
            end
            ST_START: if (sck_rise) begin
                dat_d   = 1'b1;
                state_d = ST_CDS;
            end
            ST_CDS: if (sck_rise) begin
                dat_d = 1'b0;
                if (bits_q != '0) begin
                    state_d = ST_POSN;
                    cnt_d   = bits_q;
                end else if (sbits_q != '0) begin
                    state_d = ST_STAT;
                    cnt_d   = sbits_q;
                end else begin
                    state_d = ST_CRC;
                    cnt_d   = crc_len;
                end
            end
            ST_POSN: if (sck_rise) begin
                dat_d   = posn_q[5'(cnt_q - 6'd1)];
                crc_en  = 1'b1;
                crc_din = dat_d;
                if (cnt_q != 6'd1) begin
                    cnt_d = cnt_q - 6'd1;
                end else if (sbits_q != '0) begin
                    state_d = ST_STAT;
                    cnt_d   = sbits_q;
                end else begin
                    state_d = ST_CRC;
                    cnt_d   = crc_len;
                end
            end
            ST_STAT: if (sck_rise) begin
                dat_d   = status_q[3'(cnt_q - 6'd1)];
                crc_en  = 1'b1;
                crc_din = dat_d;
                if (cnt_q != 6'd1) begin
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    state_d = ST_CRC;
                    cnt_d   = crc_len;
                end
            end
            ST_CRC: if (sck_rise) begin
                // One extra MA rising edge after the last CRC bit starts the timeout.
                if (cnt_q != '0) begin
                    dat_d = ~crc[3'(cnt_q - 6'd1)] ^ ((cnt_q == 6'd1) & err_q);
                    cnt_d = cnt_q - 6'd1;
                end else begin
                    dat_d   = 1'b0;
                    frame_d = 1'b1;
                    tmr_d   = '0;
                    state_d = ST_TIMEOUT;
                end
            end
            ST_TIMEOUT: begin
                tmr_d = tmr_q + TW'(1);
                if (tmr_hit) begin
                    dat_d   = 1'b1;
                    busy_d  = 1'b0;
                    tmr_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A master that stops clocking mid-frame is treated as an aborted frame.
        if (state_q != ST_IDLE && state_q != ST_TIMEOUT &&
            !sck_rise && !sck_fall && tmr_hit) begin
            state_d = ST_TIMEOUT;
            dat_d   = 1'b0;
            frame_d = 1'b0;
            tmr_d   = '0;
        end
    end

    assign biss_dat_o = dat_q;
    assign busy_o     = busy_q;
    assign frame_o    = frame_q;

endmodule
